j_u2txctl: RTL and testbench

UART2 transmit sequencer. Consumes the x16 baud tick `bx16` from the UART2 prescaler and serialises bytes written by the CPU onto `txd`. The block has a one-byte holding register, a shift register, configurable parity and stop bits, a break control, and overrun and interrupt signalling. It sits between the UART2 register decode (`u2dataw`, `u2ctrlw`, `u2statr`) and the serial pin.

---
 rtl/j_u2_pkg.sv | 20 ++
 rtl/j_u2tick16.sv | 28 ++
 rtl/j_u2txctl.sv | 156 +++++++++++++++
 tb/tb_j_u2txctl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j_u2_pkg.sv
// rtl/j_u2_pkg.sv - shared types and constants for the UART2 transmit sequencer
package j_u2_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Bit positions inside the control register
    localparam int PE    = 0;
    localparam int PODD  = 1;
    localparam int STOP2 = 2;
    localparam int TXBRK = 3;

    localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/j_u2tick16.sv
// rtl/j_u2tick16.sv - bx16 tick counter producing one bit_end per bit period
module j_u2tick16
    import j_u2_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic clr,
    input  logic bx16,
    output logic bit_end
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [CW-1:0] cnt;

    assign bit_end = bx16 && (cnt == CW'(OVERSAMPLE - 1));

    always_ff @(posedge sys_clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (bx16) begin
            cnt <= bit_end ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/j_u2txctl.sv
// rtl/j_u2txctl.sv - UART2 transmit sequencer: holding reg, shifter, framing FSM, flags
module j_u2txctl
    import j_u2_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       bx16,
    input  logic [7:0] din,
    input  logic       u2dataw,
    input  logic       u2ctrlw,
    input  logic       u2statr,
    output logic       txd,
    output logic       thre,
    output logic       tsre,
    output logic       overrun,
    output logic       txint
);

    localparam int BCW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    tx_state_e            state, state_d;
    logic [DATA_BITS-1:0] hold, hold_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [BCW-1:0]       bit_cnt, bit_cnt_d;
    logic [3:0]           ctrl, ctrl_d;
    logic                 snap_pe, snap_pe_d;
    logic                 snap_stop2, snap_stop2_d;
    logic                 par_bit, par_d;
    logic                 thre_d, overrun_d, txint_d, txd_d;
    logic                 transfer, accept, drop, bit_end;

    j_u2tick16 #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .sys_clk(sys_clk),
        .reset  (reset),
        .clr    (transfer),
        .bx16   (bx16),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d      = state;
        hold_d       = hold;
        shift_d      = shift;
        bit_cnt_d    = bit_cnt;
        snap_pe_d    = snap_pe;
        snap_stop2_d = snap_stop2;
        par_d        = par_bit;
        transfer     = 1'b0;
        ctrl_d       = u2ctrlw ? din[3:0] : ctrl;

        case (state)
            IDLE: begin
                if (!thre) transfer = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift >> 1;
                    if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = snap_pe ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // bit_cnt tracks which stop bit is being sent
                    if (snap_stop2 && bit_cnt == '0) begin
                        bit_cnt_d = BCW'(1);
                    end else begin
                        bit_cnt_d = '0;
                        if (!thre) transfer = 1'b1;
                        else       state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: framing options are frozen here for the whole frame
        if (transfer) begin
            state_d      = START;
            shift_d      = hold;
            bit_cnt_d    = '0;
            snap_pe_d    = ctrl[PE];
            snap_stop2_d = ctrl[STOP2];
            par_d        = (^hold) ^ ctrl[PODD];
        end

        accept    = u2dataw && (thre || transfer);
        drop      = u2dataw && !accept;
        hold_d    = accept ? din[DATA_BITS-1:0] : hold;
        thre_d    = accept ? 1'b0 : (transfer ? 1'b1 : thre);
        overrun_d = drop || (overrun && !u2statr);
        txint_d   = !thre && thre_d;

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
        if (ctrl_d[TXBRK]) txd_d = 1'b0;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state      <= IDLE;
            hold       <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            ctrl       <= '0;
            snap_pe    <= 1'b0;
            snap_stop2 <= 1'b0;
            par_bit    <= 1'b0;
            thre       <= 1'b1;
            overrun    <= 1'b0;
            txint      <= 1'b0;
            txd        <= 1'b1;
        end else begin
            state      <= state_d;
            hold       <= hold_d;
            shift      <= shift_d;
            bit_cnt    <= bit_cnt_d;
            ctrl       <= ctrl_d;
            snap_pe    <= snap_pe_d;
            snap_stop2 <= snap_stop2_d;
            par_bit    <= par_d;
            thre       <= thre_d;
            overrun    <= overrun_d;
            txint      <= txint_d;
            txd        <= txd_d;
        end
    end

    assign tsre = (state == IDLE);

endmodule

// File: tb/tb_j_u2txctl.sv
// tb/tb_j_u2txctl.sv - scoreboard bench for the UART2 transmit sequencer
module tb_j_u2txctl;

    logic       sys_clk, reset, bx16, u2dataw, u2ctrlw, u2statr;
    logic [7:0] din;
    logic       txd, thre, tsre, overrun, txint;

    j_u2txctl dut (
        .sys_clk(sys_clk), .reset(reset), .bx16(bx16), .din(din),
        .u2dataw(u2dataw), .u2ctrlw(u2ctrlw), .u2statr(u2statr),
        .txd(txd), .thre(thre), .tsre(tsre), .overrun(overrun), .txint(txint)
    );

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        logic        b2b;
    } frame_t;

    frame_t     exp_q[$];
    frame_t     cur;
    int         vectors = 0, miscompares = 0;
    int         cyc = 0, last_end = 0, start_cnt = 0, acc_cnt = 0;
    int         txint_cnt = 0, stray = 0, pos = 0, bad = 0;
    bit         mon_en, in_frame = 0, start_now;
    logic [3:0] ctrl_m;
    logic       overrun_m;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Frame as seen on the wire: start, data LSB first, optional parity, stop bit(s)
    function automatic frame_t make_frame(input logic [7:0] b, input logic [3:0] c, input logic b2b);
        frame_t f;
        int n = 0;
        f.bits = '1;
        f.bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = b[i]; n++;
        end
        if (c[0]) begin
            f.bits[n] = ($countones(b) % 2 == 1) ^ c[1]; n++;
        end
        f.bits[n] = 1'b1; n++;
        if (c[2]) begin
            f.bits[n] = 1'b1; n++;
        end
        f.nbits = n;
        f.b2b   = b2b;
        return f;
    endfunction

    always @(negedge sys_clk) begin
        if (txint) txint_cnt++;
        start_now = 1'b0;
        if (reset) begin
            in_frame = 1'b0;
        end else if (mon_en) begin
            if (!in_frame && txd === 1'b0) begin
                if (start_cnt >= exp_q.size()) begin
                    check("unexpected_start", int'(txd), 1);
                    cur = make_frame(8'hFF, 4'h0, 1'b0);
                    cur.bits = '1;
                end else begin
                    cur = exp_q[start_cnt];
                    start_cnt++;
                    check("txint_at_start", int'(txint), 1);
                    if (cur.b2b) check("b2b_gap", cyc - last_end - 1, 0);
                end
                in_frame  = 1'b1;
                pos       = 0;
                bad       = 0;
                start_now = 1'b1;
            end
            if (txint && !start_now) stray++;
            if (in_frame) begin
                if (txd !== cur.bits[pos / 16]) bad++;
                pos++;
                if (pos % 16 == 0) begin
                    check($sformatf("frame_bit%0d_bad_cycles", pos / 16 - 1), bad, 0);
                    bad = 0;
                    if (pos == cur.nbits * 16) begin
                        in_frame = 1'b0;
                        last_end = cyc;
                    end
                end
            end
        end
        cyc++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
        #1;
    endtask

    task automatic set_ctrl(input logic [3:0] c);
        @(negedge sys_clk); #1;
        din = {4'h0, c}; u2ctrlw = 1'b1;
        @(negedge sys_clk); #1;
        u2ctrlw = 1'b0;
        ctrl_m = c;
    endtask

    task automatic do_write(input logic [7:0] b);
        @(negedge sys_clk); #1;
        check("thre_vs_holding", int'(thre), int'(acc_cnt == start_cnt));
        din = b; u2dataw = 1'b1;
        if (acc_cnt == start_cnt) begin
            exp_q.push_back(make_frame(b, ctrl_m, in_frame));
            acc_cnt++;
        end else begin
            overrun_m = 1'b1;
        end
        @(negedge sys_clk); #1;
        u2dataw = 1'b0;
        check("overrun_after_write", int'(overrun), int'(overrun_m));
    endtask

    task automatic do_statr(input bit with_write, input logic [7:0] b);
        @(negedge sys_clk); #1;
        u2statr = 1'b1;
        overrun_m = 1'b0;
        if (with_write) begin
            din = b; u2dataw = 1'b1;
            if (acc_cnt == start_cnt) begin
                exp_q.push_back(make_frame(b, ctrl_m, in_frame));
                acc_cnt++;
            end else begin
                overrun_m = 1'b1;
            end
        end
        @(negedge sys_clk); #1;
        u2statr = 1'b0; u2dataw = 1'b0;
        check("overrun_after_statr", int'(overrun), int'(overrun_m));
    endtask

    task automatic wait_start();
        int n = 0;
        while (start_cnt != acc_cnt && n < 40) begin
            @(negedge sys_clk); #1;
            n++;
        end
        check("start_timeout", int'(start_cnt == acc_cnt), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(tsre && !in_frame && start_cnt == acc_cnt) && n < 3000) begin
            @(negedge sys_clk); #1;
            n++;
        end
        check("idle_timeout", int'(n < 3000), 1);
    endtask

    initial begin
        frame_t f;
        int     n, e1, e2, tc, nx;
        reset = 1'b1; bx16 = 1'b1; u2dataw = 1'b0; u2ctrlw = 1'b0; u2statr = 1'b0;
        din = 8'h00; mon_en = 1'b1; ctrl_m = 4'h0; overrun_m = 1'b0;

        wait_cycles(3);
        check("reset_txd", int'(txd), 1);
        check("reset_thre", int'(thre), 1);
        check("reset_tsre", int'(tsre), 1);
        check("reset_overrun", int'(overrun), 0);
        check("reset_txint", int'(txint), 0);
        reset = 1'b0;

        // 8N1 0xA5
        set_ctrl(4'h0);
        do_write(8'hA5);
        wait_start();
        check("tsre_busy", int'(tsre), 0);
        wait_idle();

        // 8O2 0x03
        set_ctrl(4'h7);
        do_write(8'h03);
        wait_start();
        wait_idle();

        // Back-to-back
        set_ctrl(4'h0);
        do_write(8'h55);
        wait_start();
        wait_cycles(40);
        do_write(8'hAA);
        check("thre_pending", int'(thre), 0);
        wait_idle();

        // Overrun
        do_write(8'h11);
        wait_start();
        wait_cycles(30);
        do_write(8'h22);
        do_write(8'h33);
        do_statr(1'b0, 8'h00);
        do_write(8'h44);
        do_statr(1'b1, 8'h66);
        do_statr(1'b0, 8'h00);
        wait_idle();

        // Break mid-frame, checked against the reference frame directly
        mon_en = 1'b0;
        @(negedge sys_clk); #1;
        din = 8'h5A; u2dataw = 1'b1;
        @(negedge sys_clk); #1;
        u2dataw = 1'b0;
        f = make_frame(8'h5A, 4'h0, 1'b0);
        n = 0;
        while (txd !== 1'b0 && n < 10) begin
            @(negedge sys_clk); #1;
            n++;
        end
        check("brk_start_found", int'(txd), 0);
        e1 = 0; e2 = 0;
        for (int t = 0; t < 160; t++) begin
            if (t > 0) begin
                @(negedge sys_clk); #1;
            end
            if (t >= 41 && t <= 90) begin
                if (txd !== 1'b0) e1++;
            end else if (txd !== f.bits[t / 16]) begin
                e2++;
            end
            u2ctrlw = (t == 40 || t == 90);
            din     = (t == 40) ? 8'h08 : 8'h00;
        end
        @(negedge sys_clk); #1;
        u2ctrlw = 1'b0;
        check("brk_low_errors", e1, 0);
        check("brk_frame_errors", e2, 0);
        check("brk_tsre_end", int'(tsre), 1);
        check("brk_txd_end", int'(txd), 1);
        mon_en = 1'b1;

        // Randomised frames with random framing, extra writes and status reads
        for (int it = 0; it < 10; it++) begin
            set_ctrl(4'($urandom_range(0, 7)));
            do_write(8'($urandom));
            wait_start();
            wait_cycles($urandom_range(20, 90));
            nx = $urandom_range(0, 3);
            for (int k = 0; k < nx; k++) do_write(8'($urandom));
            if (overrun_m) do_statr(1'($urandom_range(0, 1)), 8'($urandom));
            if (overrun_m) do_statr(1'b0, 8'h00);
            wait_idle();
        end

        // Reset in the middle of DATA with a pending byte and overrun set
        set_ctrl(4'h0);
        do_write(8'hC3);
        wait_start();
        wait_cycles(40);
        do_write(8'h3C);
        do_write(8'h77);
        mon_en = 1'b0;
        @(negedge sys_clk); #1;
        reset = 1'b1;
        @(negedge sys_clk); #1;
        check("midreset_txd", int'(txd), 1);
        check("midreset_thre", int'(thre), 1);
        check("midreset_tsre", int'(tsre), 1);
        check("midreset_overrun", int'(overrun), 0);
        reset = 1'b0;
        if (acc_cnt != start_cnt) begin
            void'(exp_q.pop_back());
            acc_cnt--;
        end
        overrun_m = 1'b0;
        tc = txint_cnt;
        wait_cycles(200);
        check("txint_after_reset", txint_cnt - tc, 0);
        check("txd_after_reset", int'(txd), 1);
        check("tsre_after_reset", int'(tsre), 1);
        mon_en = 1'b1;

        check("stray_txint", stray, 0);
        check("frames_started", start_cnt, acc_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
